// File: rtl/uart_cmd_handler.sv
// Host-command engine: pulls command words from the UART, performs one memory access or ping,
// and returns exactly one reply word. One command in flight at a time.
module uart_cmd_handler #(
  parameter int unsigned MEM_TIMEOUT = 1024,
  parameter logic [31:0] ACK_WORD    = 32'h00000001,
  parameter logic [31:0] NACK_WORD   = 32'hFFFFFFFF,
  parameter logic [31:0] PING_WORD   = 32'h50434921
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx_empty,
  output logic        uart_read,
  input  logic        uart_read_resp,
  input  logic [31:0] uart_read_data,
  output logic        uart_write,
  input  logic        uart_write_resp,
  output logic [31:0] uart_write_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_PING  = 8'h03;

  typedef enum logic [3:0] {
    IDLE,
    RX_REQ,
    RX_WAIT,
    RX_DRAIN,
    DECODE,
    MEM,
    TX_REQ,
    TX_WAIT,
    TX_DRAIN
  } state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [7:0]    opcode;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] reply;
  logic [TW-1:0] timer;

  // Index of the final word a memory command needs (addr only for read, addr+data for write)
  logic [1:0] last_idx_c;
  assign last_idx_c = (opcode == OP_WRITE) ? 2'd2 : 2'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      idx             <= 2'd0;
      opcode          <= 8'd0;
      addr_q          <= '0;
      data_q          <= '0;
      reply           <= '0;
      timer           <= '0;
      uart_read       <= 1'b0;
      uart_write      <= 1'b0;
      uart_write_data <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      busy            <= 1'b0;
    end else begin
      uart_read  <= 1'b0;
      uart_write <= 1'b0;
      case (state)
        IDLE: begin
          if (!uart_rx_empty) begin
            idx       <= 2'd0;
            uart_read <= 1'b1;
            busy      <= 1'b1;
            state     <= RX_REQ;
          end
        end
        // uart_read is raised on entry so it is high exactly while in RX_REQ
        RX_REQ: state <= RX_WAIT;
        RX_WAIT: begin
          if (uart_read_resp) begin
            case (idx)
              2'd0:    opcode <= uart_read_data[7:0];
              2'd1:    addr_q <= uart_read_data;
              default: data_q <= uart_read_data;
            endcase
            state <= RX_DRAIN;
          end
        end
        RX_DRAIN: begin
          if (!uart_read_resp) begin
            if (idx == 2'd0) begin
              state <= DECODE;
            end else if (idx < last_idx_c) begin
              idx       <= idx + 2'd1;
              uart_read <= 1'b1;
              state     <= RX_REQ;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= (opcode == OP_WRITE);
              mem_addr  <= addr_q;
              mem_wdata <= (opcode == OP_WRITE) ? data_q : '0;
              timer     <= '0;
              state     <= MEM;
            end
          end
        end
        DECODE: begin
          case (opcode)
            OP_PING: begin
              reply <= PING_WORD;
              state <= TX_REQ;
            end
            OP_WRITE, OP_READ: begin
              idx       <= 2'd1;
              uart_read <= 1'b1;
              state     <= RX_REQ;
            end
            default: begin
              reply <= NACK_WORD;
              state <= TX_REQ;
            end
          endcase
        end
        // An ack on the final timeout cycle still completes the access
        MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            reply   <= mem_we ? ACK_WORD : mem_rdata;
            state   <= TX_REQ;
          end else if (timer == TW'(MEM_TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            reply   <= NACK_WORD;
            state   <= TX_REQ;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        TX_REQ: begin
          uart_write_data <= reply;
          uart_write      <= 1'b1;
          state           <= TX_WAIT;
        end
        TX_WAIT: begin
          if (uart_write_resp) state <= TX_DRAIN;
        end
        TX_DRAIN: begin
          if (!uart_write_resp) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_handler.sv
// Scoreboard bench for uart_cmd_handler: UART and memory responders, reply/mem monitors.
module tb_uart_cmd_handler;

  localparam int unsigned MEM_TIMEOUT = 1024;
  localparam logic [31:0] ACK_W  = 32'h00000001;
  localparam logic [31:0] NACK_W = 32'hFFFFFFFF;
  localparam logic [31:0] PING_W = 32'h50434921;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_rx_empty;
  logic        uart_read;
  logic        uart_read_resp;
  logic [31:0] uart_read_data;
  logic        uart_write;
  logic        uart_write_resp;
  logic [31:0] uart_write_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] rx_q[$];
  logic [31:0] exp_q[$];
  mem_exp_t    mem_q[$];
  int mem_mode;
  int ack_delay;
  logic [31:0] rd_val;
  int read_cnt = 0;
  int write_cnt = 0;
  int mem_cnt = 0;
  int empty_fall_cyc = 0;
  int last_read_lat = 0;
  int ack_cyc = 0;
  int last_tx_lat = 0;

  uart_cmd_handler #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .ACK_WORD(ACK_W),
    .NACK_WORD(NACK_W),
    .PING_WORD(PING_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .uart_rx_empty(uart_rx_empty),
    .uart_read(uart_read),
    .uart_read_resp(uart_read_resp),
    .uart_read_data(uart_read_data),
    .uart_write(uart_write),
    .uart_write_resp(uart_write_resp),
    .uart_write_data(uart_write_data),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: actual=event-missing-or-extra required=none (cycle %0d)", name, cyc);
  endtask

  function automatic mem_exp_t mk(input logic we, input logic [31:0] a, input logic [31:0] d);
    mem_exp_t e;
    e.we = we;
    e.addr = a;
    e.wdata = d;
    return e;
  endfunction

  // rx FIFO empty flag follows the model queue
  initial begin
    uart_rx_empty = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (uart_rx_empty && rx_q.size() != 0) empty_fall_cyc = cyc;
      uart_rx_empty = (rx_q.size() == 0);
    end
  end

  // UART read engine: 2-cycle response two cycles after the request
  initial begin
    bit ok;
    uart_read_resp = 1'b0;
    uart_read_data = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && uart_read === 1'b1) begin
        read_cnt++;
        last_read_lat = cyc - empty_fall_cyc;
        ok = 1'b1;
        repeat (2) begin
          @(posedge clk);
          #1;
          if (uart_read !== 1'b0) ok = 1'b0;
        end
        if (rx_q.size() == 0) begin
          flag_fail("rx_underflow");
          uart_read_data = 32'h0;
        end else begin
          uart_read_data = rx_q.pop_front();
        end
        uart_read_resp = 1'b1;
        repeat (2) begin
          @(posedge clk);
          #1;
          if (uart_read !== 1'b0) ok = 1'b0;
        end
        uart_read_resp = 1'b0;
        uart_read_data = 32'h0;
        chk("read_no_reassert", 32'(ok), 32'd1);
      end
    end
  end

  // UART write engine: checks data hold and no re-pulse during the response
  initial begin
    bit ok;
    logic [31:0] held;
    uart_write_resp = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && uart_write === 1'b1) begin
        held = uart_write_data;
        ok = 1'b1;
        repeat (2) begin
          @(posedge clk);
          #1;
          if (uart_write !== 1'b0 || uart_write_data !== held) ok = 1'b0;
        end
        uart_write_resp = 1'b1;
        repeat (2) begin
          @(posedge clk);
          #1;
          if (uart_write !== 1'b0 || uart_write_data !== held) ok = 1'b0;
        end
        uart_write_resp = 1'b0;
        chk("tx_hold", 32'(ok), 32'd1);
      end
    end
  end

  // Reply monitor: pops the scoreboard on every uart_write pulse
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n === 1'b1 && uart_write === 1'b1) begin
      write_cnt++;
      last_tx_lat = cyc - ack_cyc;
      if (exp_q.size() == 0) flag_fail("unexpected_reply");
      else chk("reply", uart_write_data, exp_q.pop_front());
    end
  end

  // Memory responder and request monitor
  initial begin
    bit ok;
    int n;
    mem_exp_t e;
    logic we;
    logic [31:0] a;
    logic [31:0] d;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && mem_req === 1'b1) begin
        mem_cnt++;
        we = mem_we;
        a = mem_addr;
        d = mem_wdata;
        if (mem_q.size() == 0) begin
          flag_fail("unexpected_mem");
        end else begin
          e = mem_q.pop_front();
          chk("mem_we", 32'(we), 32'(e.we));
          chk("mem_addr", a, e.addr);
          chk("mem_wdata", d, e.wdata);
        end
        ok = 1'b1;
        n = 1;
        if (mem_mode == 0) begin
          repeat (ack_delay) begin
            @(posedge clk);
            #1;
            if (mem_req !== 1'b1 || mem_we !== we || mem_addr !== a || mem_wdata !== d) ok = 1'b0;
          end
          mem_ack = 1'b1;
          mem_rdata = rd_val;
          ack_cyc = cyc;
          @(posedge clk);
          #1;
          mem_ack = 1'b0;
          mem_rdata = 32'h0;
          chk("mem_req_drop", 32'(mem_req), 32'd0);
        end else begin
          while (mem_req === 1'b1 && n < 4000) begin
            @(posedge clk);
            #1;
            if (mem_req === 1'b1) begin
              n++;
              if (mem_we !== we || mem_addr !== a || mem_wdata !== d) ok = 1'b0;
            end
          end
          if (mem_mode == 1) chk("timeout_cycles", 32'(n), 32'(MEM_TIMEOUT));
        end
        chk("mem_stable", 32'(ok), 32'd1);
      end
    end
  end

  task automatic send(input logic [31:0] w);
    @(posedge clk);
    #1;
    rx_q.push_back(w);
  endtask

  task automatic wait_done(input int max, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || mem_q.size() != 0 || rx_q.size() != 0 ||
            busy !== 1'b0 || uart_write_resp !== 1'b0) && n < max) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (n >= max) flag_fail(name);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_uart_read"}, 32'(uart_read), 32'd0);
    chk({tag, "_uart_write"}, 32'(uart_write), 32'd0);
    chk({tag, "_uart_write_data"}, uart_write_data, 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=still-running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    int m0;
    int w0;
    int n;
    rst_n = 1'b0;
    mem_mode = 0;
    ack_delay = 3;
    rd_val = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // PING
    r0 = read_cnt;
    m0 = mem_cnt;
    exp_q.push_back(PING_W);
    send(32'h00000003);
    @(posedge clk);
    #1;
    chk("ping_busy_high", 32'(busy), 32'd1);
    wait_done(200, "ping_timeout");
    chk("ping_busy_after", 32'(busy), 32'd0);
    chk("ping_read_lat", 32'(last_read_lat), 32'd1);
    chk("ping_reads", 32'(read_cnt - r0), 32'd1);
    chk("ping_no_mem", 32'(mem_cnt - m0), 32'd0);

    // WRITE_MEM
    r0 = read_cnt;
    mem_mode = 0;
    ack_delay = 3;
    mem_q.push_back(mk(1'b1, 32'h00000100, 32'hDEADBEEF));
    exp_q.push_back(ACK_W);
    send(32'h00000001);
    send(32'h00000100);
    send(32'hDEADBEEF);
    wait_done(300, "write_timeout");
    chk("write_ack_to_tx_lat", 32'(last_tx_lat), 32'd2);
    chk("write_reads", 32'(read_cnt - r0), 32'd3);

    // READ_MEM, upper command bits set to confirm they are ignored
    rd_val = 32'hCAFEF00D;
    ack_delay = 1;
    mem_q.push_back(mk(1'b0, 32'h00000104, 32'h0));
    exp_q.push_back(32'hCAFEF00D);
    send(32'hABCDEF02);
    send(32'h00000104);
    wait_done(300, "read_timeout");
    chk("read_ack_to_tx_lat", 32'(last_tx_lat), 32'd2);

    // Unknown opcode followed by a ping queued behind it
    r0 = read_cnt;
    m0 = mem_cnt;
    exp_q.push_back(NACK_W);
    exp_q.push_back(PING_W);
    send(32'h0000007F);
    send(32'h00000003);
    wait_done(400, "unknown_timeout");
    chk("unknown_reads", 32'(read_cnt - r0), 32'd2);
    chk("unknown_no_mem", 32'(mem_cnt - m0), 32'd0);

    // READ_MEM with no ack: timeout NACK
    mem_mode = 1;
    mem_q.push_back(mk(1'b0, 32'h00000200, 32'h0));
    exp_q.push_back(NACK_W);
    send(32'h00000002);
    send(32'h00000200);
    wait_done(3000, "mem_timeout_wait");

    // Reset while in MEM: outputs clear, no reply
    mem_mode = 2;
    w0 = write_cnt;
    mem_q.push_back(mk(1'b1, 32'h00000300, 32'h12345678));
    send(32'h00000001);
    send(32'h00000300);
    send(32'h12345678);
    n = 0;
    while (mem_req !== 1'b1 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) flag_fail("reset_mem_req_wait");
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_outputs_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midreset_no_reply", 32'(write_cnt - w0), 32'd0);
    chk("midreset_idle", 32'(busy), 32'd0);

    // Recovery after reset
    mem_mode = 0;
    exp_q.push_back(PING_W);
    send(32'h00000003);
    wait_done(200, "recover_timeout");
    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("final_mem_empty", 32'(mem_q.size()), 32'd0);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
